// File: rtl/calc_ctrl.sv
// Calculator control FSM: decodes keypad commands into single-cycle datapath pulses
// and runs multiplication as repeated addition of A, counted down from B.
module calc_ctrl #(
    parameter int MAX_DIGITS = 8,
    parameter int WIDTH      = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [WIDTH-1:0] b_value,
    input  logic             dp_ovf,
    output logic             dp_clear,
    output logic             dp_push_digit,
    output logic             dp_pop_digit,
    output logic [3:0]       dp_digit,
    output logic             dp_sel_b,
    output logic [1:0]       dp_op,
    output logic             dp_exec,
    output logic             dp_acc_init,
    output logic             dp_acc_step,
    output logic             dp_result_load,
    output logic             busy,
    output logic [1:0]       status
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [3:0] CMD_ADD   = 4'd10;
    localparam logic [3:0] CMD_SUB   = 4'd11;
    localparam logic [3:0] CMD_MUL   = 4'd12;
    localparam logic [3:0] CMD_EQ    = 4'd13;
    localparam logic [3:0] CMD_BACK  = 4'd14;
    localparam logic [3:0] CMD_CLEAR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, EXEC, MUL_INIT, MUL, SHOW, ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [WIDTH-1:0]  mul_cnt_reg, mul_cnt_next;
    logic [1:0]        op_reg, op_next;
    logic [3:0]        digit_reg, digit_next;
    logic              clear_reg, clear_next;
    logic              push_reg, push_next;
    logic              pop_reg, pop_next;
    logic              exec_reg, exec_next;
    logic              init_reg, init_next;
    logic              step_reg, step_next;
    logic              load_reg, load_next;
    logic              sel_b_reg, sel_b_next;
    logic              busy_reg, busy_next;
    logic [1:0]        status_reg, status_next;

    logic       is_digit, is_oper;
    logic [1:0] cmd_op;

    assign is_digit = cmd_valid && (cmd <= 4'd9);
    assign is_oper  = cmd_valid && (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_MUL);
    assign cmd_op   = (cmd == CMD_SUB) ? OP_SUB : (cmd == CMD_MUL) ? OP_MUL : OP_ADD;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= WAIT_A;
            count_reg   <= '0;
            mul_cnt_reg <= '0;
            op_reg      <= OP_ADD;
            digit_reg   <= '0;
            clear_reg   <= 1'b0;
            push_reg    <= 1'b0;
            pop_reg     <= 1'b0;
            exec_reg    <= 1'b0;
            init_reg    <= 1'b0;
            step_reg    <= 1'b0;
            load_reg    <= 1'b0;
            sel_b_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            status_reg  <= 2'd0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            mul_cnt_reg <= mul_cnt_next;
            op_reg      <= op_next;
            digit_reg   <= digit_next;
            clear_reg   <= clear_next;
            push_reg    <= push_next;
            pop_reg     <= pop_next;
            exec_reg    <= exec_next;
            init_reg    <= init_next;
            step_reg    <= step_next;
            load_reg    <= load_next;
            sel_b_reg   <= sel_b_next;
            busy_reg    <= busy_next;
            status_reg  <= status_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        mul_cnt_next = mul_cnt_reg;
        op_next      = op_reg;
        digit_next   = digit_reg;
        clear_next   = 1'b0;
        push_next    = 1'b0;
        pop_next     = 1'b0;
        exec_next    = 1'b0;
        init_next    = 1'b0;
        step_next    = 1'b0;
        load_next    = 1'b0;

        if (cmd_valid && cmd == CMD_CLEAR) begin
            clear_next   = 1'b1;
            state_next   = WAIT_A;
            count_next   = '0;
            mul_cnt_next = '0;
            op_next      = OP_ADD;
        end else begin
            case (state_reg)
                WAIT_A, WAIT_B: begin
                    if (is_digit) begin
                        if (count_reg < CW'(MAX_DIGITS)) begin
                            push_next  = 1'b1;
                            digit_next = cmd;
                            count_next = count_reg + CW'(1);
                        end
                    end else if (cmd_valid && cmd == CMD_BACK) begin
                        if (count_reg != '0) begin
                            pop_next   = 1'b1;
                            count_next = count_reg - CW'(1);
                        end
                    end else if (is_oper) begin
                        op_next    = cmd_op;
                        state_next = WAIT_B;
                        if (state_reg == WAIT_A) count_next = '0;
                    end else if (cmd_valid && cmd == CMD_EQ && state_reg == WAIT_B) begin
                        if (op_reg == OP_MUL) begin
                            state_next = MUL_INIT;
                            init_next  = 1'b1;
                        end else begin
                            state_next = EXEC;
                            exec_next  = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (dp_ovf) begin
                        state_next = ERROR;
                    end else begin
                        state_next = SHOW;
                        load_next  = 1'b1;
                    end
                end
                MUL_INIT: begin
                    // The counter holds the steps still to issue, including the one in flight.
                    mul_cnt_next = b_value;
                    if (b_value == '0) begin
                        state_next = SHOW;
                        load_next  = 1'b1;
                    end else begin
                        state_next = MUL;
                        step_next  = 1'b1;
                    end
                end
                MUL: begin
                    if (dp_ovf) begin
                        state_next = ERROR;
                    end else begin
                        mul_cnt_next = mul_cnt_reg - WIDTH'(1);
                        if (mul_cnt_reg == WIDTH'(1)) begin
                            state_next = SHOW;
                            load_next  = 1'b1;
                        end else begin
                            step_next = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        clear_next = 1'b1;
                        push_next  = 1'b1;
                        digit_next = cmd;
                        count_next = CW'(1);
                        state_next = WAIT_A;
                    end else if (is_oper) begin
                        op_next    = cmd_op;
                        count_next = '0;
                        state_next = WAIT_B;
                    end
                end
                default: ;
            endcase
        end

        busy_next  = (state_next == EXEC) || (state_next == MUL_INIT) || (state_next == MUL);
        sel_b_next = busy_next || (state_next == WAIT_B);
        case (state_next)
            ERROR:   status_next = 2'd2;
            SHOW:    status_next = 2'd3;
            default: status_next = busy_next ? 2'd1 : 2'd0;
        endcase
    end

    assign dp_clear       = clear_reg;
    assign dp_push_digit  = push_reg;
    assign dp_pop_digit   = pop_reg;
    assign dp_digit       = digit_reg;
    assign dp_sel_b       = sel_b_reg;
    assign dp_op          = op_reg;
    assign dp_exec        = exec_reg;
    assign dp_acc_init    = init_reg;
    assign dp_acc_step    = step_reg;
    assign dp_result_load = load_reg;
    assign busy           = busy_reg;
    assign status         = status_reg;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: each command strobe is followed by checks of the
// registered outputs one cycle later, sampled on the falling edge.
module tb_calc_ctrl;

    localparam int WIDTH = 27;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       cmd;
    logic             cmd_valid;
    logic [WIDTH-1:0] b_value;
    logic             dp_ovf;
    logic             dp_clear, dp_push_digit, dp_pop_digit;
    logic [3:0]       dp_digit;
    logic             dp_sel_b;
    logic [1:0]       dp_op;
    logic             dp_exec, dp_acc_init, dp_acc_step, dp_result_load, busy;
    logic [1:0]       status;

    int checks = 0;
    int errors = 0;

    calc_ctrl #(.MAX_DIGITS(8), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .b_value(b_value), .dp_ovf(dp_ovf),
        .dp_clear(dp_clear), .dp_push_digit(dp_push_digit), .dp_pop_digit(dp_pop_digit),
        .dp_digit(dp_digit), .dp_sel_b(dp_sel_b), .dp_op(dp_op), .dp_exec(dp_exec),
        .dp_acc_init(dp_acc_init), .dp_acc_step(dp_acc_step),
        .dp_result_load(dp_result_load), .busy(busy), .status(status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after the strobe.
    task automatic send(input logic [3:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        $display("cmd %0d -> clr=%0b push=%0b pop=%0b dig=%0d selb=%0b op=%0d exec=%0b init=%0b step=%0b load=%0b busy=%0b st=%0d",
                 c, dp_clear, dp_push_digit, dp_pop_digit, dp_digit, dp_sel_b, dp_op,
                 dp_exec, dp_acc_init, dp_acc_step, dp_result_load, busy, status);
    endtask

    initial begin
        int step_cnt, busy_cnt, load_at, push_cnt, pop_cnt, load_cnt;
        reset = 1'b1; cmd = '0; cmd_valid = 1'b0; b_value = '0; dp_ovf = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_status", status, 0);
        chk("reset_busy", busy, 0);
        chk("reset_selb", dp_sel_b, 0);
        chk("reset_op", dp_op, 0);
        chk("reset_pulses", {dp_clear, dp_push_digit, dp_pop_digit, dp_exec, dp_acc_init, dp_acc_step, dp_result_load}, 0);
        reset = 1'b0;
        @(negedge clock);

        // 12 + 3 =
        send(4'd1);  chk("d1_push", dp_push_digit, 1); chk("d1_digit", dp_digit, 1); chk("d1_selb", dp_sel_b, 0);
        send(4'd2);  chk("d2_push", dp_push_digit, 1); chk("d2_digit", dp_digit, 2);
        send(4'd10); chk("add_selb", dp_sel_b, 1); chk("add_op", dp_op, 0); chk("add_push", dp_push_digit, 0);
        send(4'd3);  chk("d3_push", dp_push_digit, 1); chk("d3_digit", dp_digit, 3);
        send(4'd13); chk("eq_exec", dp_exec, 1); chk("eq_busy", busy, 1); chk("eq_status", status, 1); chk("eq_noload", dp_result_load, 0);
        @(negedge clock);
        chk("add_load", dp_result_load, 1); chk("add_exec_off", dp_exec, 0); chk("add_show", status, 3); chk("show_selb", dp_sel_b, 0);

        // Chain: result - 5 =, then a fresh digit
        send(4'd11); chk("sub_op", dp_op, 1); chk("sub_selb", dp_sel_b, 1); chk("sub_status", status, 0);
        send(4'd5);  chk("d5_push", dp_push_digit, 1);
        send(4'd13); chk("sub_exec", dp_exec, 1);
        @(negedge clock);
        chk("sub_load", dp_result_load, 1); chk("sub_show", status, 3);
        send(4'd9);
        chk("show_d9_clear", dp_clear, 1); chk("show_d9_push", dp_push_digit, 1);
        chk("show_d9_digit", dp_digit, 9); chk("show_d9_status", status, 0);

        // 7 * 4 =
        send(4'd15); chk("clr_pulse", dp_clear, 1);
        send(4'd7);
        send(4'd12); chk("mul_op", dp_op, 2);
        send(4'd4);
        b_value = 27'd4;
        send(4'd13); chk("mul_init", dp_acc_init, 1); chk("mul_init_step", dp_acc_step, 0);
        step_cnt = 0; busy_cnt = 0; load_at = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) busy_cnt++;
            if (dp_acc_step) step_cnt++;
            if (dp_result_load) begin
                load_at = i;
                break;
            end
            @(negedge clock);
        end
        chk("mul4_steps", step_cnt, 4); chk("mul4_busy", busy_cnt, 5);
        chk("mul4_load_latency", load_at, 6); chk("mul4_show", status, 3);

        // Chained multiply by B=0: load two cycles after equals
        send(4'd12);
        b_value = 27'd0;
        send(4'd13); chk("mul0_init", dp_acc_init, 1);
        @(negedge clock);
        chk("mul0_load", dp_result_load, 1); chk("mul0_nostep", dp_acc_step, 0); chk("mul0_show", status, 3);

        // Digit limit and backspace limit
        send(4'd15);
        push_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            send(4'd5);
            if (dp_push_digit) push_cnt++;
        end
        chk("nine_digits_push", push_cnt, 8);
        pop_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            send(4'd14);
            if (dp_pop_digit) pop_cnt++;
        end
        chk("nine_back_pop", pop_cnt, 8);

        // Long multiply aborted by clear
        send(4'd15);
        send(4'd3);
        send(4'd12);
        b_value = 27'd1000;
        send(4'd13);
        step_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (dp_acc_step) step_cnt++;
        end
        chk("abort_steps", step_cnt, 10);
        send(4'd15);
        chk("abort_clear", dp_clear, 1); chk("abort_noload", dp_result_load, 0);
        chk("abort_status", status, 0); chk("abort_busy", busy, 0); chk("abort_selb", dp_sel_b, 0);
        load_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (dp_result_load || dp_acc_step) load_cnt++;
        end
        chk("abort_quiet", load_cnt, 0);

        // Overflow in the exec cycle
        b_value = 27'd0;
        send(4'd2);
        send(4'd10);
        send(4'd3);
        send(4'd13); chk("ovf_exec", dp_exec, 1);
        dp_ovf = 1'b1;
        @(negedge clock);
        dp_ovf = 1'b0;
        chk("ovf_status", status, 2); chk("ovf_noload", dp_result_load, 0); chk("ovf_busy", busy, 0);
        send(4'd4);  chk("err_digit_drop", dp_push_digit, 0); chk("err_status_hold", status, 2);
        send(4'd13); chk("err_eq_drop", dp_exec, 0);
        send(4'd15); chk("err_clear", dp_clear, 1); chk("err_clear_status", status, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Control FSM that sequences the calculator datapath.
- Decodes 4-bit keypad commands and issues single-cycle control pulses: digit entry, operand select, operate, result load.
- Runs multiplication as repeated addition, counting down the second operand.
- Sits between the command input and the register/accumulator datapath. Drives the 2-bit status seen at the top level.

Parameters:
- MAX_DIGITS, 8, maximum digits per operand; further digits are ignored.
- WIDTH, 27, operand/counter width (holds 99,999,999).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- cmd  input  4  command code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 equals, 14 backspace, 15 clear.
- cmd_valid  input  1  one-cycle strobe; cmd is sampled only when high.
- b_value  input  WIDTH  current operand B from the datapath (multiplier count).
- dp_ovf  input  1  combinational overflow/underflow flag from the datapath, valid in the same cycle as dp_exec or dp_acc_step.
- dp_clear  output  1  clear A, B and accumulator.
- dp_push_digit  output  1  shift dp_digit into the selected operand (×10 + digit).
- dp_pop_digit  output  1  remove last digit of the selected operand (÷10).
- dp_digit  output  4  digit value, qualified by dp_push_digit.
- dp_sel_b  output  1  0 = entry targets A, 1 = entry targets B.
- dp_op  output  2  latched operator: 0 add, 1 sub, 2 mul.
- dp_exec  output  1  one-cycle add/sub pulse: acc <= A op B.
- dp_acc_init  output  1  acc <= 0.
- dp_acc_step  output  1  acc <= acc + A.
- dp_result_load  output  1  A <= acc; result shown.
- busy  output  1  high in EXEC and MUL.
- status  output  2  0 entry, 1 busy, 2 error, 3 result shown.

Behaviour:
- Reset:
  - state WAIT_A; all pulses 0; dp_sel_b=0; dp_op=0; digit count 0; counter 0; status=0; busy=0.
- States: WAIT_A, WAIT_B, EXEC, MUL_INIT, MUL, SHOW, ERROR.
- Clear (cmd 15, cmd_valid):
  - Accepted in every state, including EXEC and MUL (aborts them).
  - Next cycle: dp_clear=1, state WAIT_A, counters zeroed, status=0.
- Digit entry:
  - Digit in WAIT_A/WAIT_B: dp_push_digit=1 the next cycle if digit count < MAX_DIGITS; otherwise dropped.
  - Backspace: dp_pop_digit=1 if count > 0; otherwise dropped.
  - The digit count tracks the active operand and resets to 0 on entering WAIT_B.
- Operators (10/11/12):
  - In WAIT_A: latch dp_op, go to WAIT_B, dp_sel_b=1. An empty A counts as 0.
  - In WAIT_B: replace dp_op only; no execution.
- Equals (13):
  - In WAIT_A: ignored.
  - In WAIT_B, op add/sub: EXEC for one cycle (dp_exec=1), then dp_result_load the following cycle, then SHOW.
  - In WAIT_B, op mul: MUL_INIT for one cycle (dp_acc_init=1, counter <= b_value), then MUL.
    - In MUL, counter != 0: dp_acc_step=1, counter-1.
    - In MUL, counter == 0: dp_result_load=1, go to SHOW.
    - Latency from the equals strobe to dp_result_load = b_value + 2 cycles; B=0 gives result 0 after 2 cycles.
- Overflow:
  - dp_ovf high in a cycle with dp_exec or dp_acc_step → ERROR next cycle, no dp_result_load, status=2.
  - ERROR accepts only clear.
- SHOW (status=3):
  - Digit: dp_clear and dp_push_digit in the same cycle (datapath clears, then loads the digit); go to WAIT_A with count=1.
  - Operator: chain the result as A; latch op; go to WAIT_B.
  - Equals/backspace: ignored.
- While busy: all commands except clear are dropped, with no queueing.
- dp_sel_b is 0 in WAIT_A and SHOW, 1 in WAIT_B. In EXEC/MUL it holds 1, and its value is don't-care there.
- All outputs are registered; every pulse is exactly one cycle wide.
- cmd_valid asserted on consecutive cycles is decoded once per cycle.

Test Plan:
- Reset, then digits 1,2 → two dp_push_digit pulses (digit 1, then 2), dp_sel_b=0; then add, 3, equals → dp_exec one cycle after equals, dp_result_load one cycle later, status=3.
- 7, mul, 4, equals → dp_acc_init, then exactly 4 dp_acc_step pulses, dp_result_load 6 cycles after the equals strobe; busy high for 5 cycles.
- Nine digits into A with MAX_DIGITS=8 → 8 push pulses, ninth dropped; backspace ×9 → 8 pop pulses, ninth dropped.
- mul with b_value=1000, clear strobed after 10 steps → dp_clear next cycle, no dp_result_load, state WAIT_A, status=0, busy=0.
- add with dp_ovf forced high in the dp_exec cycle → status=2; subsequent digits and equals ignored; clear restores status=0.
- After a result (status=3): sub, 5, equals → dp_op=1, dp_exec issued, result chained; then digit 9 → dp_clear and dp_push_digit in the same cycle.
